// File: rtl/qmac_accum.sv
// Fixed-point dot-product accumulator: sums LEN sign-magnitude products plus a bias
// and returns a saturated sign-magnitude result through a valid/ready handshake.
module qmac_accum #(
  parameter int N   = 16,
  parameter int Q   = 8,
  parameter int LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for the first product of a vector
  // ACC   | vector partially accumulated
  // OUT   | result pending until the consumer takes it

  localparam int CW = $clog2(LEN + 1);
  localparam int W  = N + CW;
  localparam logic [W-1:0] MAXMAG = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};

  if (LEN < 1 || LEN > 256) begin : g_len_chk
    $error("qmac_accum: LEN must be in 1..256");
  end
  if (Q < 0 || Q > N - 1) begin : g_q_chk
    $error("qmac_accum: Q must be in 0..N-1");
  end

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t              state;
  logic signed [W-1:0] acc;
  logic [CW-1:0]       cnt;
  logic                sat_flag;

  logic                take;
  logic                last;
  logic signed [W-1:0] base;
  logic signed [W-1:0] term;
  logic signed [W-1:0] sum_next;
  logic                neg;
  logic [W-1:0]        abs_sum;
  logic                res_sat;
  logic                ovf_next;
  logic [N-1:0]        res;

  // Negative zero maps to zero because -0 == 0 in two's complement.
  function automatic logic signed [W-1:0] sm_to_tc(input logic [N-1:0] sm);
    logic signed [W-1:0] mag;
    mag = signed'({{(W-N+1){1'b0}}, sm[N-2:0]});
    return sm[N-1] ? -mag : mag;
  endfunction

  always_comb begin
    take     = in_valid & in_ready;
    base     = (state == IDLE) ? sm_to_tc(bias) : acc;
    term     = sm_to_tc(in_data);
    sum_next = base + term;
    neg      = sum_next[W-1];
    abs_sum  = neg ? unsigned'(-sum_next) : unsigned'(sum_next);
    res_sat  = abs_sum > MAXMAG;
    // neg implies a nonzero magnitude, so negative zero never appears
    res      = res_sat ? {neg, MAXMAG[N-2:0]} : {neg, abs_sum[N-2:0]};
    ovf_next = ((state == ACC) & sat_flag) | in_ovf;
    last     = (state == IDLE) ? (LEN == 1) : (cnt == CW'(LEN - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          in_ready <= 1'b1;
          if (take) begin
            acc      <= sum_next;
            cnt      <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
            sat_flag <= ovf_next;
            busy     <= 1'b1;
            if (last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= res;
              out_sat   <= ovf_next | res_sat;
            end else begin
              state <= ACC;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qmac_accum.sv
// Self-checking bench for qmac_accum (N=16, Q=8, LEN=4) against an integer reference model.
module tb_qmac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int hs_count = 0;

  logic [15:0] v_bias;
  logic [15:0] v_term [4];
  logic        v_ovf  [4];

  logic [15:0] dir_bias [4] = '{16'h0000, 16'h0100, 16'h0100, 16'h8000};
  logic [15:0] dir_term [4][4] = '{
    '{16'h0100, 16'h0200, 16'h8080, 16'h0040},
    '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
    '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
    '{16'h8000, 16'h0000, 16'h8000, 16'h0000}};
  logic [15:0] dir_exp_d [4] = '{16'h02C0, 16'h7FFF, 16'hFFFF, 16'h0000};
  logic        dir_exp_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  qmac_accum #(.N(16), .Q(8), .LEN(4)) dut (
    .clk(clk), .rst(rst), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy));

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1 && out_ready === 1'b1) hs_count++;

  function automatic int sm2int(input logic [15:0] v);
    int m;
    m = int'({17'b0, v[14:0]});
    return v[15] ? -m : m;
  endfunction

  // Expected {sat, data} from the current vector: exact integer sum, then clamp.
  function automatic logic [16:0] model();
    int          sum;
    logic        s;
    logic [15:0] d;
    sum = sm2int(v_bias);
    s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum += sm2int(v_term[i]);
      s |= v_ovf[i];
    end
    if (sum > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (sum < -32767) begin
      d = 16'hFFFF; s = 1'b1;
    end else if (sum < 0) begin
      d = {1'b1, 15'(-sum)};
    end else begin
      d = 16'(sum);
    end
    return {s, d};
  endfunction

  task automatic send_vector(input int max_gap, output bit timeout);
    timeout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int g;
      int w;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_ovf   = 1'($urandom);
        bias     = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v_term[i];
      in_ovf   = v_ovf[i];
      bias     = (i == 0) ? v_bias : 16'($urandom);
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
        @(posedge clk); #1; w++;
      end
      if (in_ready !== 1'b1) timeout = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_ovf   = 1'b0;
  endtask

  task automatic take_result(input int delay, output logic [15:0] d, output logic s,
                             output bit stable, output bit held);
    d = out_data;
    s = out_sat;
    stable = 1'b1;
    held = (in_ready === 1'b0);
    repeat (delay) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== d || out_sat !== s) stable = 1'b0;
      if (in_ready !== 1'b0) held = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0000) $display("FAIL rst_out_data: got %h want 0000", out_data); else passed++;
    total++; if (out_sat !== 1'b0) $display("FAIL rst_out_sat: got %b want 0", out_sat); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_release_early: in_ready=%b want 0", in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: in_ready=%b want 1", in_ready); else passed++;
  endtask

  task automatic test_directed();
    bit to, st, hd;
    logic [15:0] d;
    logic s;
    for (int k = 0; k < 4; k++) begin
      v_bias = dir_bias[k];
      for (int i = 0; i < 4; i++) begin
        v_term[i] = dir_term[k][i];
        v_ovf[i]  = 1'b0;
      end
      send_vector(0, to);
      total++; if (to) $display("FAIL dir%0d_timeout: in_ready never high", k); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL dir%0d_latency: out_valid=%b want 1", k, out_valid); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL dir%0d_busy: got %b want 1", k, busy); else passed++;
      take_result(0, d, s, st, hd);
      total++; if (d !== dir_exp_d[k]) $display("FAIL dir%0d_data: got %h want %h", k, d, dir_exp_d[k]); else passed++;
      total++; if (s !== dir_exp_s[k]) $display("FAIL dir%0d_sat: got %b want %b", k, s, dir_exp_s[k]); else passed++;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL dir%0d_handoff: out_valid=%b busy=%b want 0 0", k, out_valid, busy); else passed++;
    end
  endtask

  task automatic test_gaps_backpressure();
    bit to, st, hd;
    logic [15:0] d;
    logic s;
    logic [16:0] e;
    int hs0;
    v_bias = 16'h0080;
    for (int i = 0; i < 4; i++) begin
      v_term[i] = {1'($urandom), 15'($urandom) & 15'h0FFF};
      v_ovf[i]  = (i == 1);
    end
    e = model();
    hs0 = hs_count;
    send_vector(4, to);
    total++; if (to) $display("FAIL gap_timeout: in_ready never high"); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL gap_latency: out_valid=%b want 1", out_valid); else passed++;
    take_result(3, d, s, st, hd);
    total++; if (!st) $display("FAIL gap_stable: output changed while stalled, final %h want %h", out_data, d); else passed++;
    total++; if (!hd) $display("FAIL gap_in_ready: in_ready high while result pending, got 1 want 0"); else passed++;
    total++; if (d !== e[15:0]) $display("FAIL gap_data: got %h want %h", d, e[15:0]); else passed++;
    total++; if (s !== 1'b1) $display("FAIL gap_ovf_sat: got %b want 1", s); else passed++;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (hs_count - hs0 !== 1) $display("FAIL gap_handoffs: got %0d want 1", hs_count - hs0); else passed++;
  endtask

  task automatic test_back_to_back();
    bit to, st, hd;
    logic [15:0] d;
    logic s;
    logic [16:0] e;
    v_bias = 16'h8100;
    for (int i = 0; i < 4; i++) begin
      v_term[i] = {1'($urandom), 15'($urandom) & 15'h03FF};
      v_ovf[i]  = 1'b0;
    end
    e = model();
    send_vector(0, to);
    total++; if (out_data !== e[15:0] || out_sat !== e[16]) $display("FAIL b2b_first: got %b/%h want %b/%h", out_sat, out_data, e[16], e[15:0]); else passed++;
    in_valid  = 1'b1;
    in_data   = 16'($urandom);
    in_ovf    = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_return: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); else passed++;
    v_bias = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      v_term[i] = {1'($urandom), 15'($urandom) & 15'h03FF};
      v_ovf[i]  = 1'b0;
    end
    e = model();
    send_vector(0, to);
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_latency: out_valid=%b want 1", out_valid); else passed++;
    take_result(1, d, s, st, hd);
    total++; if (d !== e[15:0] || s !== e[16]) $display("FAIL b2b_second: got %b/%h want %b/%h", s, d, e[16], e[15:0]); else passed++;
  endtask

  task automatic test_reset_mid();
    bit to, st, hd;
    logic [15:0] d;
    logic s;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h7000;
      in_ovf   = 1'b1;
      bias     = 16'h7000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst_ctl: in_ready=%b busy=%b out_valid=%b want 0 0 0", in_ready, busy, out_valid); else passed++;
    total++; if (out_data !== 16'h0000 || out_sat !== 1'b0) $display("FAIL midrst_out: got %b/%h want 0/0000", out_sat, out_data); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL midrst_release: in_ready=%b want 1", in_ready); else passed++;
    v_bias = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      v_term[i] = 16'h0100;
      v_ovf[i]  = 1'b0;
    end
    send_vector(0, to);
    total++; if (out_valid !== 1'b1) $display("FAIL midrst_latency: out_valid=%b want 1", out_valid); else passed++;
    take_result(0, d, s, st, hd);
    total++; if (d !== 16'h0400 || s !== 1'b0) $display("FAIL midrst_result: got %b/%h want 0/0400", s, d); else passed++;
  endtask

  task automatic test_random();
    bit to, st, hd;
    logic [15:0] d;
    logic s;
    logic [16:0] e;
    for (int n = 0; n < 24; n++) begin
      v_bias = {1'($urandom), 15'($urandom) & 15'h0FFF};
      for (int i = 0; i < 4; i++) begin
        logic [14:0] m;
        case ($urandom_range(2, 0))
          0:       m = 15'($urandom) & 15'h00FF;
          1:       m = 15'($urandom) & 15'h1FFF;
          default: m = 15'($urandom);
        endcase
        v_term[i] = {1'($urandom), m};
        if ($urandom_range(9, 0) == 0) v_term[i] = 16'h8000;
        v_ovf[i] = ($urandom_range(7, 0) == 0);
      end
      e = model();
      send_vector(2, to);
      total++; if (to || out_valid !== 1'b1) $display("FAIL rnd%0d_latency: timeout=%b out_valid=%b want 0 1", n, to, out_valid); else passed++;
      take_result(int'($urandom_range(2, 0)), d, s, st, hd);
      total++; if (d !== e[15:0] || s !== e[16]) $display("FAIL rnd%0d_result: got %b/%h want %b/%h", n, s, d, e[16], e[15:0]); else passed++;
      total++; if (!st || !hd) $display("FAIL rnd%0d_hold: stable=%b in_ready_low=%b want 1 1", n, st, hd); else passed++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ovf    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_gaps_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/qmac_accum.md
QMAC_ACCUM -- requirements
Module: qmac_accum

Interface
REQ-001 Parameter N, default 16, total word width of products, bias and result.
REQ-002 Parameter Q, default 8, fractional bits; fixes the Q format only, no arithmetic effect inside the block.
REQ-003 Parameter LEN, default 4, number of products per dot product; legal range 1..256.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 bias  input  N  sign-magnitude Q(N,Q) bias; sampled on the cycle the first product of a vector is accepted.
REQ-007 in_valid  input  1  product word present on in_data.
REQ-008 in_ready  output  1  block can accept a product this cycle.
REQ-009 in_data  input  N  product in multiplier output format: bit N-1 sign, bits N-2:0 magnitude with Q fractional bits.
REQ-010 in_ovf  input  1  multiplier overflow flag for the product on in_data; qualified by in_valid.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  N  sign-magnitude Q(N,Q) result.
REQ-014 out_sat  output  1  result saturated, or an input overflow occurred in this vector.
REQ-015 busy  output  1  high while a vector is partially accumulated or a result is pending.

Function
REQ-016 A transfer occurs on a cycle with in_valid and in_ready both high; only transfers advance the term counter.
REQ-017 A result handoff occurs on a cycle with out_valid and out_ready both high.
REQ-018 FSM states: IDLE, ACC, OUT.
REQ-019 IDLE: in_ready=1, out_valid=0, busy=0; on transfer the accumulator loads bias plus term, count=1, sat flag loads in_ovf, and the FSM goes to ACC, or to OUT if LEN=1.
REQ-020 ACC: in_ready=1, busy=1; on transfer the accumulator adds the term, sat flag ORs in_ovf, and count increments; a transfer with count=LEN-1 moves the FSM to OUT.
REQ-021 OUT: in_ready=0, out_valid=1, busy=1; out_data and out_sat are held stable until handoff, after which the FSM returns to IDLE.
REQ-022 Latency: out_valid rises on the cycle after the LEN-th transfer; there is no combinational path from in_valid or in_data to any output.
REQ-023 Terms and bias are converted from sign-magnitude to two's complement before addition; 0x80..0 (negative zero) equals zero.
REQ-024 Accumulator width is W = N + ceil(log2(LEN+1)), two's complement; no intermediate overflow is possible.
REQ-025 Final result saturates to magnitude 2^(N-1)-1 with the sign kept; saturation sets out_sat.
REQ-026 out_data is re-encoded to sign-magnitude and never shows negative zero; a zero sum gives all-zeros.
REQ-027 in_valid gaps of any length within a vector are allowed; the accumulator holds its value during gaps.
REQ-028 Back-to-back vectors: the first product of the next vector is accepted no earlier than the cycle after handoff, because in_ready is 0 in OUT.

Reset
REQ-029 While rst is high: FSM=IDLE, accumulator=0, count=0, sat flag=0, out_valid=0, out_data=0, out_sat=0, busy=0, and in_ready=0.
REQ-030 Reset during ACC or OUT discards the partial or pending result; the next vector after release is unaffected by prior state.
REQ-031 in_ready rises on the first clock edge after rst deasserts.

Verification (N=16, Q=8, LEN=4)
REQ-032 bias=0x0000; terms 0x0100, 0x0200, 0x8080, 0x0040 back-to-back -> out_data=0x02C0 (2.75), out_sat=0, out_valid one cycle after the 4th transfer.
REQ-033 bias=0x0100; four terms 0x7FFF -> out_data=0x7FFF, out_sat=1. Four terms 0xFFFF -> out_data=0xFFFF, out_sat=1.
REQ-034 Terms 0x8000, 0x0000, 0x8000, 0x0000 with bias=0x8000 -> out_data=0x0000, out_sat=0.
REQ-035 Random in_valid gaps, and out_ready low for 3 cycles -> in_ready=0 throughout, out_data stable, exactly one handoff; in_ovf=1 on the 2nd term -> correct sum and out_sat=1.
REQ-036 rst pulse after 2 transfers -> all outputs reach reset values immediately; the following vector 0x0100 x4 with bias 0 -> out_data=0x0400, out_sat=0.
